// File: rtl/conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_sched
// Brief    : Walks an IMG_W x IMG_H image in raster order. For each window it
//            fetches a 3x3 pixel window, runs it through an external MAC, and
//            streams the 32-bit results out.
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_sched #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mac_start,
    output logic [71:0]       mac_window,
    input  logic              mac_done,
    input  logic [31:0]       mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [15:0]       out_row,
    output logic [15:0]       out_col
);

    localparam logic [ADDR_W-1:0] c_IMG_W    = ADDR_W'(IMG_W);
    localparam logic [15:0]       c_LAST_COL = 16'(IMG_W - 3);
    localparam logic [15:0]       c_LAST_ROW = 16'(IMG_H - 3);
    localparam logic [3:0]        c_LAST_FC  = 4'd9;
    localparam logic [3:0]        c_LAST_RD  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t            r_state;
    logic [15:0]       r_row;
    logic [15:0]       r_col;
    logic [3:0]        r_fc;
    logic              r_busy;
    logic              r_done;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_mac_start;
    logic [71:0]       r_window;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic [15:0]       r_out_row;
    logic [15:0]       r_out_col;

    logic              w_last_win;
    logic [15:0]       w_next_row;
    logic [15:0]       w_next_col;
    logic [3:0]        w_fc_nxt;

    // Address of window pixel k (row-major inside the 3x3 window).
    function automatic logic [ADDR_W-1:0] f_addr(input logic [15:0] row,
                                                 input logic [15:0] col,
                                                 input logic [3:0]  k);
        logic [1:0] dy;
        logic [1:0] dx;
        if (k >= 4'd6) begin
            dy = 2'd2;
            dx = 2'(k - 4'd6);
        end else if (k >= 4'd3) begin
            dy = 2'd1;
            dx = 2'(k - 4'd3);
        end else begin
            dy = 2'd0;
            dx = k[1:0];
        end
        return (ADDR_W'(row) + ADDR_W'(dy)) * c_IMG_W + ADDR_W'(col) + ADDR_W'(dx);
    endfunction

    always_comb begin
        w_last_win = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);
        w_fc_nxt   = r_fc + 4'd1;
        w_next_row = r_row;
        w_next_col = r_col + 16'd1;
        if (r_col == c_LAST_COL) begin
            w_next_row = r_row + 16'd1;
            w_next_col = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= 16'd0;
            r_col       <= 16'd0;
            r_fc        <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_mac_start <= 1'b0;
            r_window    <= 72'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_row   <= 16'd0;
            r_out_col   <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row   <= 16'd0;
                        r_col   <= 16'd0;
                        r_fc    <= 4'd0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_addr  <= f_addr(16'd0, 16'd0, 4'd0);
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // Read data for slot fc-1 arrives one cycle after its strobe.
                    for (int k = 0; k < 9; k++) begin
                        if (r_fc == 4'(k + 1))
                            r_window[8*k +: 8] <= mem_rd_data;
                    end
                    if (r_fc == c_LAST_FC) begin
                        r_mac_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else begin
                        r_fc <= w_fc_nxt;
                        if (w_fc_nxt <= c_LAST_RD) begin
                            r_rd_en <= 1'b1;
                            r_addr  <= f_addr(r_row, r_col, w_fc_nxt);
                        end else begin
                            r_rd_en <= 1'b0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_mac_start <= 1'b0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_done) begin
                        r_out_data  <= mac_result;
                        r_out_row   <= r_row;
                        r_out_col   <= r_col;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last_win) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row   <= w_next_row;
                            r_col   <= w_next_col;
                            r_fc    <= 4'd0;
                            r_rd_en <= 1'b1;
                            r_addr  <= f_addr(w_next_row, w_next_col, 4'd0);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign mem_rd_en  = r_rd_en;
    assign mem_addr   = r_addr;
    assign mac_start  = r_mac_start;
    assign mac_window = r_window;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_sched
// Brief    : Scoreboard bench; instance 0 runs a 3x3 image, instance 1 a 4x4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_sched;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] row;
        logic [15:0] col;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start      [2];
    logic        busy       [2];
    logic        done       [2];
    logic        rd_en      [2];
    logic [15:0] mem_addr   [2];
    logic        mac_start  [2];
    logic [71:0] win        [2];
    logic        inj_done   [2];
    logic        out_valid  [2];
    logic        out_ready  [2];
    logic [31:0] out_data   [2];
    logic [15:0] out_row    [2];
    logic [15:0] out_col    [2];
    int          lat        [2];

    res_t        exp_q [2][$];
    logic [15:0] exp_addr [$];

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int n_res [2];
    int n_done [2];
    int n_mstart [2];
    int hs_cyc [2];
    int done_cyc [2];
    int last_rise [2];
    bit chk13 = 1'b0;

    always #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] f_sum(input logic [71:0] w);
        logic [31:0] s = 32'd0;
        for (int k = 0; k < 9; k++) s = s + 32'(w[8*k +: 8]);
        return s;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_dut
        logic        stub_done;
        logic [31:0] stub_res;
        logic [7:0]  rd_data;
        logic        pend;
        int          cnt;
        logic [31:0] held;

        conv_window_sched #(.IMG_W(3 + i), .IMG_H(3 + i), .ADDR_W(16)) u_dut (
            .clk(clk), .rst(rst), .start(start[i]), .busy(busy[i]), .done(done[i]),
            .mem_rd_en(rd_en[i]), .mem_addr(mem_addr[i]), .mem_rd_data(rd_data),
            .mac_start(mac_start[i]), .mac_window(win[i]),
            .mac_done(stub_done | inj_done[i]), .mac_result(stub_res),
            .out_valid(out_valid[i]), .out_ready(out_ready[i]), .out_data(out_data[i]),
            .out_row(out_row[i]), .out_col(out_col[i])
        );

        // Image 0 holds 1..9; image 1 holds p(r,c)=4r+c, i.e. its own address.
        always @(posedge clk) begin
            if (rd_en[i]) rd_data <= 8'(mem_addr[i]) + 8'(1 - i);
        end

        // Summing MAC stub: mac_done arrives lat+1 cycles after mac_start.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                stub_done <= 1'b0;
                stub_res  <= 32'd0;
                pend      <= 1'b0;
                cnt       <= 0;
                held      <= 32'd0;
            end else begin
                stub_done <= 1'b0;
                if (mac_start[i]) begin
                    if (lat[i] == 0) begin
                        stub_done <= 1'b1;
                        stub_res  <= f_sum(win[i]);
                    end else begin
                        pend <= 1'b1;
                        cnt  <= lat[i];
                        held <= f_sum(win[i]);
                    end
                end else if (pend) begin
                    if (cnt == 1) begin
                        stub_done <= 1'b1;
                        stub_res  <= held;
                        pend      <= 1'b0;
                    end else begin
                        cnt <= cnt - 1;
                    end
                end
            end
        end

        initial begin
            res_t e;
            bit   prev_valid = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_valid = 1'b0;
                end else begin
                    if (out_valid[i] && out_ready[i]) begin
                        if (exp_q[i].size() == 0) begin
                            chk($sformatf("unexpected_result_i%0d", i),
                                {out_data[i], out_row[i], out_col[i]}, 96'hdead);
                        end else begin
                            e = exp_q[i].pop_front();
                            chk($sformatf("result_i%0d", i),
                                {out_data[i], out_row[i], out_col[i]}, e);
                        end
                        n_res[i]++;
                        hs_cyc[i] = cyc;
                    end
                    if (done[i]) begin
                        n_done[i]++;
                        done_cyc[i] = cyc;
                    end
                    if (mac_start[i]) n_mstart[i]++;
                    if (out_valid[i] && !prev_valid) begin
                        if (chk13 && last_rise[i] >= 0)
                            chk("valid_spacing", 96'(cyc - last_rise[i]), 96'd13);
                        last_rise[i] = cyc;
                    end
                    prev_valid = out_valid[i];
                    if (i == 1 && rd_en[i] && exp_addr.size() > 0)
                        chk("mem_addr", 96'(mem_addr[i]), 96'(exp_addr.pop_front()));
                end
            end
        end
    end

    task automatic clr(input int i);
        n_res[i] = 0; n_done[i] = 0; n_mstart[i] = 0;
        hs_cyc[i] = -1; done_cyc[i] = -1; last_rise[i] = -1;
    endtask

    task automatic pulse_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int k = 0;
        while (!done[i] && k < budget) begin @(negedge clk); k++; end
        if (k >= budget) chk($sformatf("done_timeout_i%0d", i), 96'd0, 96'd1);
        @(posedge clk); #1;
    endtask

    task automatic push4();
        exp_q[1].push_back({32'd45, 16'd0, 16'd0});
        exp_q[1].push_back({32'd54, 16'd0, 16'd1});
        exp_q[1].push_back({32'd81, 16'd1, 16'd0});
        exp_q[1].push_back({32'd90, 16'd1, 16'd1});
    endtask

    task automatic chk_idle_outs(input string nm, input int i);
        chk(nm, {busy[i], done[i], rd_en[i], mac_start[i], out_valid[i], mem_addr[i],
                 out_data[i], out_row[i], out_col[i]}, 96'd0);
        chk({nm, "_window"}, 96'(win[i]), 96'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; inj_done[i] = 1'b0; out_ready[i] = 1'b1; lat[i] = 2;
            clr(i);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outs("reset_i0", 0);
        chk_idle_outs("reset_i1", 1);
        @(posedge clk); #1 rst = 1'b0;

        // 3x3 image: one result, done the cycle after the handshake.
        exp_q[0].push_back({32'd45, 16'd0, 16'd0});
        pulse_start(0);
        wait_done(0, 200);
        chk("i0_results", 96'(n_res[0]), 96'd1);
        chk("i0_done_at_h1", 96'(done_cyc[0] - hs_cyc[0]), 96'd1);
        repeat (3) @(posedge clk);
        #1 chk("i0_done_once", 96'(n_done[0]), 96'd1);
        chk("i0_idle_busy", 96'(busy[0]), 96'd0);

        // 4x4 frame: address order, back-pressure, ignored start/mac_done.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int p = 0; p < 9; p++)
                    exp_addr.push_back(16'((r + p / 3) * 4 + c + p % 3));
        push4();
        out_ready[1] = 1'b0;
        @(posedge clk); #1 inj_done[1] = 1'b1;
        @(posedge clk); #1 inj_done[1] = 1'b0;
        pulse_start(1);
        repeat (3) @(posedge clk);
        #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        k = 0;
        while (!out_valid[1] && k < 100) begin @(negedge clk); k++; end
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 96'(out_valid[1]), 96'd1);
            chk("stall_data", {out_data[1], out_row[1], out_col[1]}, {32'd45, 16'd0, 16'd0});
            chk("stall_no_read", 96'(rd_en[1]), 96'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready[1] = 1'b1;
        k = 0;
        while (n_mstart[1] < 2 && k < 100) begin @(posedge clk); k++; end
        #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        wait_done(1, 400);
        chk("i1_results", 96'(n_res[1]), 96'd4);
        chk("i1_done_at_h1", 96'(done_cyc[1] - hs_cyc[1]), 96'd1);
        chk("i1_addr_all_seen", 96'(exp_addr.size()), 96'd0);

        // Reset during WAIT of the second window, then a full frame again.
        clr(1);
        push4();
        pulse_start(1);
        k = 0;
        while (n_mstart[1] < 2 && k < 100) begin @(posedge clk); k++; end
        #1 rst = 1'b1;
        @(negedge clk);
        chk_idle_outs("abort", 1);
        exp_q[1].delete();
        @(posedge clk); #1 rst = 1'b0;
        k = 0;
        repeat (20) begin @(negedge clk); if (out_valid[1] || done[1]) k++; end
        chk("no_output_after_abort", 96'(k), 96'd0);
        clr(1);
        push4();
        pulse_start(1);
        wait_done(1, 400);
        chk("restart_results", 96'(n_res[1]), 96'd4);

        // Zero-latency MAC with ready high: 13-cycle result cadence.
        clr(1);
        lat[1] = 0;
        chk13 = 1'b1;
        push4();
        pulse_start(1);
        wait_done(1, 400);
        chk13 = 1'b0;
        chk("fast_results", 96'(n_res[1]), 96'd4);
        chk("leftover_i0", 96'(exp_q[0].size()), 96'd0);
        chk("leftover_i1", 96'(exp_q[1].size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
`default_nettype wire
